model: RTL and testbench

- Small fixed-topology 4-layer CNN accelerator for 4x4, 2-channel, 8-bit frames.
- Runs conv0 (3x3, 2->2), conv1 (1x1, 2->4), conv2 (3x3, 4->2) and conv3 (1x1, 2->2), all with stride 1, dilation 1, zero padding (pad 1 for 3x3, pad 0 for 1x1), requantisation and ReLU.
- Uses one sequential MAC over on-chip feature-map registers.
- Produces two heads: "vertical" (conv2 output) and "cls" (conv3 output), both streamed to downstream FIFOs.

---
 rtl/model.sv | 194 +++++++++++++++++++
 tb/tb_model.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/model.sv
// Fixed 4-layer CNN (3x3 -> 1x1 -> 3x3 -> 1x1) on 4x4x2 frames using a single sequential MAC.
// Define MODEL_ROUND_EN for round-half-up requantisation (floor otherwise).
module model #(
  parameter int IN_WIDTH  = 4,
  parameter int IN_HEIGHT = 4,
  parameter int IN_CH     = 2,
  parameter int OUT_CH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*IN_CH-1:0]    i_data,
  input  logic                  i_valid,
  output logic                  fifo_rd_en,
  input  logic                  cls_almost_full,
  input  logic                  vertical_almost_full,
  input  logic [31:0]           weight_wr_data,
  input  logic [31:0]           weight_wr_addr,
  input  logic                  weight_wr_en,
  output logic [8*OUT_CH-1:0]   o_data_cls,
  output logic [8*OUT_CH-1:0]   o_data_vertical,
  output logic                  o_valid_cls,
  output logic                  o_valid_vertical
);

  localparam int NPIX = IN_WIDTH * IN_HEIGHT;
  localparam int NW   = 134;
  localparam logic [3:0] PIX_LAST = 4'(NPIX - 1);
  localparam logic [1:0] S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_OUTPUT = 2'd2;
`ifdef MODEL_ROUND_EN
  localparam logic signed [63:0] RND = 64'sh8000;
`else
  localparam logic signed [63:0] RND = 64'sh0;
`endif

  logic [1:0] state, layer, oc, ky, kx, c;
  logic [3:0] pix;
  logic       wr_phase;
  logic signed [31:0] acc;

  logic [7:0]         wmem  [NW];
  logic signed [31:0] bias  [10];
  logic [15:0]        coeff [4];
  // fm[0] = input frame, fm[l+1] = output of conv l; up to 4 channels each
  logic [7:0]         fm    [5][16][4];

  // ---------------- parameter writes ----------------
  logic kern_hit;
  assign kern_hit = (weight_wr_addr <= 32'd35) ||
                    (weight_wr_addr >= 32'd40  && weight_wr_addr <= 32'd47) ||
                    (weight_wr_addr >= 32'd54  && weight_wr_addr <= 32'd125) ||
                    (weight_wr_addr >= 32'd130 && weight_wr_addr <= 32'd133);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NW; i++) wmem[i] <= '0;
      for (int i = 0; i < 10; i++) bias[i] <= '0;
      for (int i = 0; i < 4; i++)  coeff[i] <= '0;
    end else if (weight_wr_en) begin
      if (kern_hit) wmem[weight_wr_addr[7:0]] <= weight_wr_data[7:0];
      case (weight_wr_addr)
        32'd36:  bias[0]  <= weight_wr_data;
        32'd37:  bias[1]  <= weight_wr_data;
        32'd38:  coeff[0] <= weight_wr_data[15:0];
        32'd48:  bias[2]  <= weight_wr_data;
        32'd49:  bias[3]  <= weight_wr_data;
        32'd50:  bias[4]  <= weight_wr_data;
        32'd51:  bias[5]  <= weight_wr_data;
        32'd52:  coeff[1] <= weight_wr_data[15:0];
        32'd126: bias[6]  <= weight_wr_data;
        32'd127: bias[7]  <= weight_wr_data;
        32'd128: coeff[2] <= weight_wr_data[15:0];
        32'd134: bias[8]  <= weight_wr_data;
        32'd135: bias[9]  <= weight_wr_data;
        32'd136: coeff[3] <= weight_wr_data[15:0];
        default: ;
      endcase
    end
  end

  // ---------------- per-layer geometry ----------------
  logic       k3;
  logic [1:0] ic_last, oc_last, k_last;
  logic [7:0] kbase, kstride, krow;
  logic [3:0] bbase;

  always_comb begin
    k3 = 1'b0; ic_last = 2'd1; oc_last = 2'd1;
    kbase = 8'd130; kstride = 8'd2; krow = 8'd0; bbase = 4'd8;
    case (layer)
      2'd0: begin k3 = 1'b1; kbase = 8'd0;  kstride = 8'd18; krow = 8'd6;  bbase = 4'd0; end
      2'd1: begin oc_last = 2'd3; kbase = 8'd40; bbase = 4'd2; end
      2'd2: begin k3 = 1'b1; ic_last = 2'd3; kbase = 8'd54; kstride = 8'd36; krow = 8'd12; bbase = 4'd6; end
      default: ;
    endcase
    k_last = k3 ? 2'd2 : 2'd0;
  end

  // Padding: coordinates outside 0..3 (including -1 wrapping to 15) read as zero
  logic [3:0] iy, ix;
  logic       inb;
  logic [7:0] xv, wv, waddr;
  logic signed [31:0] xs, ws, prod;

  always_comb begin
    iy    = {2'b0, pix[3:2]} + {2'b0, ky} - {3'b0, k3};
    ix    = {2'b0, pix[1:0]} + {2'b0, kx} - {3'b0, k3};
    inb   = (iy < 4'd4) && (ix < 4'd4);
    xv    = inb ? fm[layer][{iy[1:0], ix[1:0]}][c] : 8'd0;
    waddr = kbase + {6'b0, oc} * kstride + {6'b0, ky} * krow
          + {6'b0, kx} * ({6'b0, ic_last} + 8'd1) + {6'b0, c};
    wv    = wmem[waddr];
    xs    = {24'b0, xv};
    ws    = {{24{wv[7]}}, wv};
    prod  = xs * ws;
  end

  // ---------------- requantise + ReLU/saturate ----------------
  logic signed [31:0] bsel;
  logic signed [63:0] acc64, cf64, b64, r;
  logic [7:0]         q;

  always_comb begin
    bsel  = bias[bbase + {2'b0, oc}];
    acc64 = {{32{acc[31]}}, acc};
    cf64  = {48'b0, coeff[layer]};
    b64   = {{32{bsel[31]}}, bsel};
    r     = (acc64 * cf64 + b64 + RND) >>> 16;
    if (r[63])              q = 8'd0;
    else if (r > 64'sd255)  q = 8'd255;
    else                    q = r[7:0];
  end

  logic [2:0] dst;
  assign dst = {1'b0, layer} + 3'd1;

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_LOAD; layer <= '0; pix <= '0; oc <= '0;
      ky <= '0; kx <= '0; c <= '0; wr_phase <= 1'b0; acc <= '0;
      for (int l = 0; l < 5; l++)
        for (int p = 0; p < 16; p++)
          for (int k = 0; k < 4; k++) fm[l][p][k] <= '0;
    end else begin
      case (state)
        S_LOAD: if (i_valid) begin
          fm[0][pix][0] <= i_data[7:0];
          fm[0][pix][1] <= i_data[15:8];
          if (pix == PIX_LAST) begin pix <= '0; state <= S_COMPUTE; end
          else pix <= pix + 4'd1;
        end
        S_COMPUTE: if (!wr_phase) begin
          acc <= acc + prod;
          if (c == ic_last) begin
            c <= '0;
            if (kx == k_last) begin
              kx <= '0;
              if (ky == k_last) begin ky <= '0; wr_phase <= 1'b1; end
              else ky <= ky + 2'd1;
            end else kx <= kx + 2'd1;
          end else c <= c + 2'd1;
        end else begin
          fm[dst][pix][oc] <= q;
          acc <= '0;
          wr_phase <= 1'b0;
          if (oc == oc_last) begin
            oc <= '0;
            if (pix == PIX_LAST) begin
              pix <= '0;
              if (layer == 2'd3) begin layer <= '0; state <= S_OUTPUT; end
              else layer <= layer + 2'd1;
            end else pix <= pix + 4'd1;
          end else oc <= oc + 2'd1;
        end
        S_OUTPUT: if (!cls_almost_full && !vertical_almost_full) begin
          if (pix == PIX_LAST) begin pix <= '0; state <= S_LOAD; end
          else pix <= pix + 4'd1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Outputs are driven straight from the feature maps so a stalled pixel holds
  logic out_act, emit;
  assign out_act          = (state == S_OUTPUT) && !rst_n;
  assign emit             = out_act && !cls_almost_full && !vertical_almost_full;
  assign fifo_rd_en       = (state == S_LOAD) && !rst_n;
  assign o_valid_cls      = emit;
  assign o_valid_vertical = emit;
  assign o_data_cls       = out_act ? {fm[4][pix][1], fm[4][pix][0]} : '0;
  assign o_data_vertical  = out_act ? {fm[3][pix][1], fm[3][pix][0]} : '0;

endmodule

// File: tb/tb_model.sv
// Self-checking bench for model: scoreboard of expected output pixels plus a table of bias/clamp vectors.
module tb_model;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0, fifo_rd_en;
  logic        cls_af = 1'b0, vert_af = 1'b0;
  logic [31:0] wdata = '0, waddr = '0;
  logic        wen = 1'b0;
  logic [15:0] o_data_cls, o_data_vertical;
  logic        o_valid_cls, o_valid_vertical;

  model dut (
    .clk(clk), .rst_n(rst), .i_data(i_data), .i_valid(i_valid), .fifo_rd_en(fifo_rd_en),
    .cls_almost_full(cls_af), .vertical_almost_full(vert_af),
    .weight_wr_data(wdata), .weight_wr_addr(waddr), .weight_wr_en(wen),
    .o_data_cls(o_data_cls), .o_data_vertical(o_data_vertical),
    .o_valid_cls(o_valid_cls), .o_valid_vertical(o_valid_vertical)
  );

  always #5 clk = ~clk;

  typedef logic [15:0] frame_t [16];
  typedef struct { logic [15:0] v; logic [15:0] c; } exp_t;
  typedef struct { logic [31:0] b2; logic [31:0] b3; logic [15:0] ev; logic [15:0] ec; } vec_t;

  exp_t sb[$];
  int checks = 0, failures = 0, out_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (o_valid_cls || o_valid_vertical)) begin
      exp_t e;
      chk("valid_pair", {31'b0, o_valid_cls}, {31'b0, o_valid_vertical});
      if (sb.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("vertical", {16'b0, o_data_vertical}, {16'b0, e.v});
        chk("cls", {16'b0, o_data_cls}, {16'b0, e.c});
      end
      out_cnt++;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    waddr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic send_pixels(input frame_t px);
    for (int i = 0; i < 16; i++) begin
      bit done, now;
      done = 0;
      i_data = px[i];
      i_valid = ($urandom_range(0, 3) != 0);
      for (int t = 0; t < 50 && !done; t++) begin
        @(negedge clk); now = fifo_rd_en && i_valid;
        @(posedge clk); #1;
        if (now) done = 1; else i_valid = 1'b1;
      end
      if (!done) chk("load_accept", 32'd0, 32'd1);
    end
  endtask

  task automatic run_frame(input frame_t px, input frame_t ev, input frame_t ec, input bit bp);
    int lat, rd_hi;
    for (int i = 0; i < 16; i++) sb.push_back('{ev[i], ec[i]});
    out_cnt = 0; rd_hi = 0; lat = 0;
    send_pixels(px);
    i_valid = 1'b1; i_data = 16'hFFFF;   // must be ignored outside LOAD
    forever begin
      @(negedge clk);
      if (o_valid_cls || o_valid_vertical || lat >= 5000) break;
      if (fifo_rd_en) rd_hi++;
      lat++;
    end
    i_valid = 1'b0;
    chk("latency", 32'(lat), 32'd2080);
    if (bp) begin
      for (int t = 0; t < 100 && out_cnt < 3; t++) begin @(negedge clk); #1; end
      chk("bp_reach3", 32'(out_cnt), 32'd3);
      @(posedge clk); #1 cls_af = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("bp_valids_low", {30'b0, o_valid_cls, o_valid_vertical}, 32'd0);
        chk("bp_data_hold", {16'b0, o_data_cls}, {16'b0, ec[3]});
      end
      @(posedge clk); #1 cls_af = 1'b0;
    end
    for (int t = 0; t < 100 && out_cnt < 16; t++) begin
      @(negedge clk); #1;
      if (fifo_rd_en && out_cnt < 16) rd_hi++;
    end
    chk("out_count", 32'(out_cnt), 32'd16);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("rd_en_low", 32'(rd_hi), 32'd0);
    @(negedge clk);
    chk("back_to_load", {31'b0, fifo_rd_en}, 32'd1);
  endtask

  task automatic set_bias(input logic [31:0] b2, input logic [31:0] b3);
    wr(32'd126, b2); wr(32'd127, b2); wr(32'd134, b3); wr(32'd135, b3);
  endtask

  task automatic chk_idle(input string nm, input logic rd_exp);
    chk({nm, "_rd_en"}, {31'b0, fifo_rd_en}, {31'b0, rd_exp});
    chk({nm, "_valids"}, {30'b0, o_valid_cls, o_valid_vertical}, 32'd0);
    chk({nm, "_data"}, {o_data_cls, o_data_vertical}, 32'd0);
  endtask

  initial begin
    vec_t   tbl [4];
    frame_t px, ev, ec;

    tbl[0] = '{32'h0003_0000, 32'h0004_0000, 16'h0303, 16'h0404};   // bias-only
    tbl[1] = '{32'h8000_0000, 32'hFFFF_0000, 16'h0000, 16'h0000};   // clamp low
    tbl[2] = '{32'h0100_0000, 32'h0300_0000, 16'hFFFF, 16'hFFFF};   // clamp high
`ifdef MODEL_ROUND_EN
    tbl[3] = '{32'h0007_8000, 32'h0000_FFFF, 16'h0808, 16'h0101};
`else
    tbl[3] = '{32'h0007_8000, 32'h0000_FFFF, 16'h0707, 16'h0000};
`endif

    // reset
    repeat (5) @(posedge clk);
    @(negedge clk); chk_idle("in_reset", 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk_idle("after_reset", 1'b1);

    // table-driven bias / clamp / rounding vectors (kernels and coeffs are zero)
    for (int k = 0; k < 4; k++) begin
      set_bias(tbl[k].b2, tbl[k].b3);
      for (int p = 0; p < 16; p++) begin
        px[p] = 16'($urandom);
        ev[p] = tbl[k].ev;
        ec[p] = tbl[k].ec;
      end
      run_frame(px, ev, ec, 1'b0);
    end

    // identity chain
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    foreach (px[p]) ;
    wr(32'd38, 32'h1234_8000); wr(32'd52, 32'h1234_8000);
    wr(32'd128, 32'h1234_8000); wr(32'd136, 32'h1234_8000);
    wr(32'd8, 32'hFFFF_FF02);  wr(32'd27, 32'hFFFF_FF02);
    wr(32'd40, 32'hFFFF_FF02); wr(32'd43, 32'hFFFF_FF02);
    wr(32'd70, 32'hFFFF_FF02); wr(32'd107, 32'hFFFF_FF02);
    wr(32'd130, 32'hFFFF_FF02); wr(32'd133, 32'hFFFF_FF02);
    wr(32'd39, 32'hFFFF_FFFF); wr(32'd53, 32'hFFFF_FFFF);
    wr(32'd129, 32'hFFFF_FFFF); wr(32'd137, 32'hFFFF_FFFF); wr(32'd300, 32'hFFFF_FFFF);
    for (int p = 0; p < 16; p++) begin
      px[p] = {8'(p + 1), 8'(p + 1)};
      ev[p] = px[p]; ec[p] = px[p];
    end
    run_frame(px, ev, ec, 1'b0);

    // distinct channels
    for (int p = 0; p < 16; p++) begin
      px[p] = {8'(p + 33), 8'(p + 1)};
      ev[p] = px[p]; ec[p] = px[p];
    end
    run_frame(px, ev, ec, 1'b0);

    // ch0 taken from the top-left tap: exercises the zero padding border
    wr(32'd8, 32'h0); wr(32'd0, 32'hFFFF_FF02);
    for (int p = 0; p < 16; p++) begin
      logic [7:0] s;
      s = ((p / 4) > 0 && (p % 4) > 0) ? 8'(p - 4) : 8'd0;
      ev[p] = {8'(p + 33), s}; ec[p] = ev[p];
    end
    run_frame(px, ev, ec, 1'b0);
    wr(32'd0, 32'h0); wr(32'd8, 32'h0000_0002);

    // backpressure
    for (int p = 0; p < 16; p++) begin
      px[p] = {8'(p + 1), 8'(p + 1)};
      ev[p] = px[p]; ec[p] = px[p];
    end
    run_frame(px, ev, ec, 1'b1);

    // reset in the middle of conv2
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_bias(32'h0003_0000, 32'h0004_0000);
    for (int p = 0; p < 16; p++) px[p] = 16'($urandom);
    send_pixels(px);
    i_valid = 1'b0;
    repeat (608 + 192 + 400) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk_idle("midreset", 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); chk_idle("midreset_after", 1'b1);
    set_bias(32'h0003_0000, 32'h0004_0000);
    for (int p = 0; p < 16; p++) begin
      px[p] = 16'($urandom);
      ev[p] = 16'h0303; ec[p] = 16'h0404;
    end
    run_frame(px, ev, ec, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
